key_schedule_ctrl: RTL

//  AES-128 key-expansion sequencer; sits directly upstream of GenSubKey and drives it.
//  On start it latches the cipher key and issues 10 requests to GenSubKey, one per round.

---
 rtl/key_schedule_ctrl_pkg.sv | 15 +
 rtl/key_schedule_ctrl_rcon_lut.sv | 33 +++
 rtl/key_schedule_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/key_schedule_ctrl_pkg.sv
// Shared sizes and FSM encoding for the AES-128 key-expansion sequencer.
package key_schedule_ctrl_pkg;

   localparam int KS_KEY_LEN    = 128;
   localparam int KS_WORD_LEN   = 32;
   localparam int KS_NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/key_schedule_ctrl_rcon_lut.sv
// Round constant lookup: 4-bit round index -> {RCON, 24'h0}, zero outside rounds 1..10.
module key_schedule_ctrl_rcon_lut
   import key_schedule_ctrl_pkg::*;
#(
   parameter int WORD_LEN = KS_WORD_LEN
) (
   input  logic [3:0]          i_round,
   output logic [WORD_LEN-1:0] o_rcon
);

   logic [7:0] w_byte;

   // NOTE: default first so every path assigns w_byte and no latch is inferred.
   always_comb begin
      w_byte = 8'h00;
      case (i_round)
         4'd1:    w_byte = 8'h01;
         4'd2:    w_byte = 8'h02;
         4'd3:    w_byte = 8'h04;
         4'd4:    w_byte = 8'h08;
         4'd5:    w_byte = 8'h10;
         4'd6:    w_byte = 8'h20;
         4'd7:    w_byte = 8'h40;
         4'd8:    w_byte = 8'h80;
         4'd9:    w_byte = 8'h1b;
         4'd10:   w_byte = 8'h36;
         default: w_byte = 8'h00;
      endcase
   end

   assign o_rcon = {w_byte, {(WORD_LEN-8){1'b0}}};

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-expansion sequencer: drives GenSubKey one round at a time and stores
// the 11 round keys in a local register file with a combinational read port.
module key_schedule_ctrl
   import key_schedule_ctrl_pkg::*;
#(
   parameter int KEY_LEN    = KS_KEY_LEN,
   parameter int WORD_LEN   = KS_WORD_LEN,
   parameter int NUM_ROUNDS = KS_NUM_ROUNDS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [KEY_LEN-1:0]  key_in,
   output logic                busy,
   output logic                done,
   output logic                keys_valid,
   input  logic [3:0]          rk_rd_addr,
   output logic [KEY_LEN-1:0]  rk_rd_data,
   output logic                gsk_valid_in,
   output logic [KEY_LEN-1:0]  gsk_data_in,
   output logic [WORD_LEN-1:0] gsk_rcon,
   output logic                gsk_opcode,
   input  logic [KEY_LEN-1:0]  gsk_data_out,
   input  logic                gsk_valid_out
);

   state_t             r_state;
   state_t             w_next;
   logic [3:0]         r_round;
   logic               r_keys_valid;
   logic [KEY_LEN-1:0] r_rk [0:NUM_ROUNDS];

   logic               w_start_ok;
   logic               w_rk_wr;
   logic               w_last;
   logic [3:0]         w_prev_idx;
   logic [WORD_LEN-1:0] w_rcon;

   assign w_start_ok = (r_state == ST_IDLE) && start;
   assign w_rk_wr    = (r_state == ST_WAIT) && gsk_valid_out;
   assign w_last     = (r_round == 4'(NUM_ROUNDS));
   assign w_prev_idx = r_round - 4'd1;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_ISSUE;
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT:  if (gsk_valid_out) w_next = w_last ? ST_DONE : ST_ISSUE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_round      <= 4'd0;
         r_keys_valid <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_round      <= 4'd1;
            r_keys_valid <= 1'b0;
         end else if (w_rk_wr && !w_last) begin
            r_round <= r_round + 4'd1;
         end
         if (r_state == ST_DONE) r_keys_valid <= 1'b1;
      end
   end

   // NOTE: the key store is reset explicitly; a stale schedule must never survive reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
      end else if (w_start_ok) begin
         r_rk[0] <= key_in;
      end else if (w_rk_wr) begin
         r_rk[r_round] <= gsk_data_out;
      end
   end

   key_schedule_ctrl_rcon_lut #(
      .WORD_LEN (WORD_LEN)
   ) u_rcon_lut (
      .i_round (r_round),
      .o_rcon  (w_rcon)
   );

   assign busy         = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign done         = (r_state == ST_DONE);
   assign keys_valid   = r_keys_valid;
   assign gsk_valid_in = (r_state == ST_ISSUE);
   assign gsk_opcode   = 1'b0;

   // Request fields come straight from state that only moves on the return handshake,
   // so they stay stable for GenSubKey's late Rcon use.
   assign gsk_data_in = busy ? r_rk[w_prev_idx] : '0;
   assign gsk_rcon    = busy ? w_rcon : '0;
   assign rk_rd_data  = (rk_rd_addr <= 4'(NUM_ROUNDS)) ? r_rk[rk_rd_addr] : '0;

endmodule
